// File: rtl/skinny_sbox8_dom1_sequencer_pkg.sv
// Shared constants and FSM encoding for the DOM-1 SKINNY sbox8 sequencer.
package skinny_sbox8_dom1_sequencer_pkg;

    localparam int unsigned NSTAGE = 4;
    localparam int unsigned NSTEP  = 6;
    localparam int unsigned NCYC   = NSTAGE * NSTEP;

    typedef enum logic [2:0] {
        StIdle,
        StWrnd,
        StRun,
        StCapt,
        StDone
    } state_e;

endpackage

// File: rtl/skinny_sbox8_step_gen.sv
// Step counter with registered one-hot decode; drives the core's per-step enables.
module skinny_sbox8_step_gen #(
    parameter int unsigned NCYC = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    output logic [NCYC-1:0] cycle,
    output logic            done
);

    localparam int unsigned   CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    logic [CW-1:0]   cnt_q;
    logic [NCYC-1:0] cycle_q;

    assign done  = (cnt_q == LAST);
    assign cycle = cycle_q;

    // The counter parks at zero after the last step, so it can never run past LAST.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            cycle_q <= '0;
        end else if (start) begin
            cnt_q   <= '0;
            cycle_q <= NCYC'(1);
        end else if (step) begin
            if (done) begin
                cnt_q   <= '0;
                cycle_q <= '0;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                cycle_q <= NCYC'(1) << (cnt_q + 1'b1);
            end
        end
    end

endmodule

// File: rtl/skinny_sbox8_dom1_sequencer.sv
// Handshaked sequencer around an external DOM-1 masked SKINNY sbox8 core.
// Shares stay on separate register paths; they are never combined here.
module skinny_sbox8_dom1_sequencer #(
    parameter int unsigned NSTAGE = skinny_sbox8_dom1_sequencer_pkg::NSTAGE,
    parameter int unsigned NSTEP  = skinny_sbox8_dom1_sequencer_pkg::NSTEP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              di0,
    input  logic [7:0]              di1,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    input  logic [7:0]              rnd,
    output logic [7:0]              si0,
    output logic [7:0]              si1,
    output logic [7:0]              r,
    output logic [NSTAGE*NSTEP-1:0] cycle,
    input  logic [7:0]              bo0,
    input  logic [7:0]              bo1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              do0,
    output logic [7:0]              do1
);

    localparam int unsigned NCYC = NSTAGE * NSTEP;

    import skinny_sbox8_dom1_sequencer_pkg::*;

    state_e state;
    logic   step_start;
    logic   step_run;
    logic   step_done;

    assign step_start = (state == StWrnd) && rnd_valid;
    assign step_run   = (state == StRun);

    skinny_sbox8_step_gen #(
        .NCYC (NCYC)
    ) u_step_gen (
        .clk   (clk),
        .rst   (rst),
        .start (step_start),
        .step  (step_run),
        .cycle (cycle),
        .done  (step_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            si0       <= '0;
            si1       <= '0;
            r         <= '0;
            do0       <= '0;
            do1       <= '0;
            in_ready  <= 1'b1;
            rnd_ready <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        si0       <= di0;
                        si1       <= di1;
                        in_ready  <= 1'b0;
                        rnd_ready <= 1'b1;
                        state     <= StWrnd;
                    end
                end
                StWrnd: begin
                    if (rnd_valid) begin
                        r         <= rnd;
                        rnd_ready <= 1'b0;
                        state     <= StRun;
                    end
                end
                StRun: begin
                    if (step_done) begin
                        state <= StCapt;
                    end
                end
                StCapt: begin
                    do0       <= bo0;
                    do1       <= bo1;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    // Scrub core inputs so no stale share or mask lingers between ops.
                    if (out_ready) begin
                        si0       <= '0;
                        si1       <= '0;
                        r         <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skinny_sbox8_dom1_sequencer.sv
// Self-checking bench: timeline model of the sequencer plus a behavioural sbox8 core.
module tb_skinny_sbox8_dom1_sequencer;

    localparam int NCYC = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      di0 = 8'h00;
    logic [7:0]      di1 = 8'h00;
    logic            rnd_valid = 1'b0;
    logic            rnd_ready;
    logic [7:0]      rnd = 8'h00;
    logic [7:0]      si0;
    logic [7:0]      si1;
    logic [7:0]      r;
    logic [NCYC-1:0] cycle;
    logic [7:0]      bo0 = 8'h00;
    logic [7:0]      bo1 = 8'h00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      do0;
    logic [7:0]      do1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skinny_sbox8_dom1_sequencer #(
        .NSTAGE (4),
        .NSTEP  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .di0       (di0),
        .di1       (di1),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd       (rnd),
        .si0       (si0),
        .si1       (si1),
        .r         (r),
        .cycle     (cycle),
        .bo0       (bo0),
        .bo1       (bo1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .do0       (do0),
        .do1       (do1)
    );

    // SKINNY-128 8-bit sbox from its round definition (NOR-XOR mix and bit permutation).
    function automatic logic [7:0] sbox(input logic [7:0] x_in);
        logic [7:0] x;
        x = x_in;
        for (int i = 0; i < 4; i++) begin
            x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
            if (i < 3) begin
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                    ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
            end
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Timeline model: phase 0 idle, 1 waiting for mask, 2 processing, 3 result held.
    int         n = 0;
    int         ph = 0;
    int         e_r = 0;
    logic [7:0] x_si0 = 8'h00;
    logic [7:0] x_si1 = 8'h00;
    logic [7:0] x_r = 8'h00;
    logic [7:0] x_doxor = 8'h00;

    always @(posedge clk) begin
        n++;
        if (!rst) begin
            ph = 0; x_si0 = 8'h00; x_si1 = 8'h00; x_r = 8'h00; x_doxor = 8'h00;
        end else begin
            case (ph)
                0: if (in_valid) begin ph = 1; x_si0 = di0; x_si1 = di1; end
                1: if (rnd_valid) begin ph = 2; x_r = rnd; e_r = n; end
                2: if (n == e_r + NCYC + 1) begin ph = 3; x_doxor = sbox(x_si0 ^ x_si1); end
                default: if (out_ready) begin
                    ph = 0; x_si0 = 8'h00; x_si1 = 8'h00; x_r = 8'h00;
                end
            endcase
        end
    end

    // Behavioural core: output shares are valid only in the cycle after the last step.
    logic       last_q = 1'b0;
    logic [7:0] cmask;
    always @(posedge clk) begin
        #1;
        if (last_q) begin
            cmask = 8'($urandom);
            bo0   = cmask;
            bo1   = sbox(si0 ^ si1) ^ cmask;
        end else begin
            bo0 = 8'($urandom);
            bo1 = 8'($urandom);
        end
        last_q = cycle[NCYC-1];
    end

    logic [NCYC-1:0] exp_cyc;
    logic [7:0]      h0, h1;
    bit              held_v = 1'b0;

    always @(negedge clk) begin
        if (n > 0) begin
            exp_cyc = '0;
            if (ph == 2 && (n - e_r) < NCYC) exp_cyc[n - e_r] = 1'b1;
            check("cycle", 32'(cycle), 32'(exp_cyc));
            check("cycle_onehot", 32'($countones(cycle) <= 1), 32'd1);
            check("in_ready", 32'(in_ready), 32'(ph == 0));
            check("rnd_ready", 32'(rnd_ready), 32'(ph == 1));
            check("out_valid", 32'(out_valid), 32'(ph == 3));
            check("si0", 32'(si0), 32'(x_si0));
            check("si1", 32'(si1), 32'(x_si1));
            check("r", 32'(r), 32'(x_r));
            check("do_xor", 32'(do0 ^ do1), 32'(x_doxor));
            if (ph == 3 && held_v) begin
                check("do0_stable", 32'(do0), 32'(h0));
                check("do1_stable", 32'(do1), 32'(h1));
            end
            held_v = (ph == 3);
            h0 = do0;
            h1 = do1;
        end
    end

    int         t_in;
    logic [7:0] res;

    task automatic do_in(input logic [7:0] a, input logic [7:0] b);
        bit got = 1'b0;
        di0 = a; di1 = b; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin t_in = n + 1; got = 1'b1; end
            @(posedge clk); #2;
            if (got) break;
        end
        if (!got) check("in_handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; di0 = 8'($urandom); di1 = 8'($urandom);
    endtask

    task automatic do_rnd(input logic [7:0] m, input int rdel);
        bit got = 1'b0;
        rnd = 8'($urandom);
        repeat (rdel) begin @(posedge clk); #2; end
        rnd = m; rnd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rnd_ready) got = 1'b1;
            @(posedge clk); #2;
            if (got) break;
        end
        if (!got) check("rnd_handshake_timeout", 32'd0, 32'd1);
        rnd_valid = 1'b0; rnd = 8'($urandom);
    endtask

    task automatic do_out(input int odel, input int rdel);
        int ov_cnt = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!out_valid) begin
                if (ov_cnt > 0) break;
            end else begin
                ov_cnt++;
                if (ov_cnt == 1) begin
                    check("latency", 32'(n + 1 - t_in), 32'(27 + rdel));
                    res = do0 ^ do1;
                end
                if (ov_cnt == odel + 1) out_ready = 1'b1;
            end
        end
        out_ready = 1'b0;
        check("out_valid_cycles", 32'(ov_cnt), 32'(odel + 1));
        @(posedge clk); #2;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                          input int rdel, input int odel);
        do_in(a, b);
        do_rnd(m, rdel);
        do_out(odel, rdel);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cycle"}, 32'(cycle), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rnd_ready"}, 32'(rnd_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_regs"}, 32'({si0, si1, r, do0 | do1}), 32'd0);
    endtask

    localparam logic [NCYC-1:0] BIT12 = NCYC'(1) << 12;

    initial begin
        logic [7:0] x;
        logic [7:0] s0;
        bit         got;

        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #2;
        rst = 1'b1;

        run_op(8'h00, 8'h00, 8'hA5, 0, 0);
        check("s_00", 32'(res), 32'h65);
        run_op(8'h3C, 8'hC3, 8'h5A, 0, 1);
        check("s_ff_mask5a", 32'(res), 32'hFF);
        run_op(8'h3C, 8'hC3, 8'h96, 0, 0);
        check("s_ff_mask96", 32'(res), 32'hFF);
        run_op(8'h55, 8'h54, 8'($urandom), 0, 0);
        check("s_01", 32'(res), 32'h4C);

        // Mask delayed 10 cycles; latency check in do_out expects 37.
        run_op(8'($urandom), 8'($urandom), 8'($urandom), 10, 0);
        // Downstream stalls 5 cycles; expects 6 cycles of out_valid.
        run_op(8'($urandom), 8'($urandom), 8'($urandom), 0, 5);

        // Abort mid-run at step 12.
        do_in(8'h12, 8'h34);
        do_rnd(8'h77, 0);
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cycle == BIT12) begin got = 1'b1; break; end
        end
        check("reach_step12", 32'(got), 32'd1);
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        reset_checks("abort");
        repeat (30) @(posedge clk);
        #2;
        run_op(8'h9A, 8'h9A, 8'($urandom), 0, 0);
        check("s_00_after_abort", 32'(res), 32'h65);

        for (int i = 0; i < 256; i++) begin
            x  = 8'(i);
            s0 = 8'($urandom);
            run_op(s0, s0 ^ x, 8'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/skinny_sbox8_dom1_sequencer.md
SKINNY_SBOX8_DOM1_SEQUENCER -- requirements
Module: skinny_sbox8_dom1_sequencer

Interface
REQ-001 SHALL have parameter NSTAGE, default 4: number of serial core-function stages in the sbox8.
REQ-002 SHALL have parameter NSTEP, default 6: steps per core-function stage; NCYC = NSTAGE*NSTEP (24).
REQ-003 SHALL have a single clock; reset is synchronous and active-low.
REQ-004 Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- in_valid  input  1  upstream shares valid
- in_ready  output  1  block accepts shares
- di0 / di1  input  8  input byte share 0 / share 1
- rnd_valid  input  1  fresh mask from the PRNG is valid
- rnd_ready  output  1  block consumes the mask
- rnd  input  8  fresh refreshing mask
- si0 / si1  output  8  registered shares driven to the masked sbox8 core
- r  output  8  registered mask driven to the core
- cycle  output  NCYC  one-hot step enable driven to the core
- bo0 / bo1  input  8  core output shares
- out_valid  output  1  result shares valid
- out_ready  input  1  downstream accepts result
- do0 / do1  output  8  registered result shares

Function
REQ-005 SHALL implement the FSM IDLE -> WRND -> RUN -> CAPT -> DONE -> IDLE.
REQ-006 IDLE: in_ready=1; on in_valid=1, register di0->si0 and di1->si1 and go to WRND.
REQ-007 WRND: rnd_ready=1; on rnd_valid=1, register rnd->r, clear step counter, and go to RUN; otherwise stay in WRND.
REQ-008 RUN: cycle = 1<<cnt for cnt 0..NCYC-1, one bit per clock; after cnt=NCYC-1, go to CAPT.
REQ-009 cycle SHALL be all-zero in every state other than RUN, and exactly one-hot in RUN.
REQ-010 CAPT: register bo0->do0 and bo1->do1, then go to DONE.
REQ-011 DONE: out_valid=1, with do0/do1 held stable; on out_ready=1, go to IDLE.
REQ-012 Latency: in-handshake at edge T, with rnd_valid already high, gives out_valid high from cycle T+27.
REQ-013 si0, si1 and r SHALL hold constant from leaving WRND until leaving CAPT.
REQ-014 Shares SHALL never be combined (no XOR or other logic between share-0 and share-1 paths) anywhere in the block.
REQ-015 On the DONE->IDLE transition, si0, si1 and r SHALL be cleared to zero (no stale shares or mask left on the core inputs).
REQ-016 in_ready and rnd_ready SHALL be 0 outside IDLE and WRND respectively; in_valid and rnd_valid are ignored outside those states.
REQ-017 The counter width is clog2(NCYC); it SHALL never exceed NCYC-1 (no wrap-around into RUN).
REQ-018 in_ready SHALL rise the cycle after the DONE->IDLE transition, giving back-to-back operation with one idle cycle.

Reset
REQ-019 When rst=0 at a clock edge: state=IDLE, cnt=0, and si0, si1, r, do0, do1 are all zero.
REQ-020 After reset: cycle=0, out_valid=0, rnd_ready=0, in_ready=1.
REQ-021 Reset during RUN SHALL abort the operation; cycle SHALL be zero in the cycle following the reset edge, and no out_valid SHALL be produced for the aborted operation.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding, NSTAGE, NSTEP and NCYC.
REQ-023 A sub-module skinny_sbox8_step_gen (counter plus one-hot decode, with start/done signals) is natural; the masked sbox8 core stays external and connects through si*, r, cycle and bo*.

Verification (bench instantiates this block plus the DOM masked sbox8 core)
REQ-024 di0=0x00, di1=0x00, rnd=0xA5 -> do0^do1 = 0x65, out_valid at T+27.
REQ-025 di0=0x3C, di1=0xC3, rnd=0x5A -> do0^do1 = S(0xFF) = 0xFF; a different rnd SHALL give the same XOR result.
REQ-026 rnd_valid held low for 10 cycles after the in-handshake -> FSM stays in WRND, cycle=0 throughout, out_valid delayed by exactly 10 cycles.
REQ-027 out_ready held low for 5 cycles in DONE -> do0/do1 stable and in_ready=0 throughout; handshake completes on the 6th cycle.
REQ-028 rst=0 at RUN cnt=12 -> next cycle shows cycle=0, all registers zero, state IDLE; a following operation produces a correct result.
REQ-029 Exhaustive 256 inputs with random shares and masks -> every do0^do1 matches the SKINNY 8-bit sbox table; one-hot property of cycle asserted every cycle.
